// File: rtl/svf_ctrl_mixer.sv
// svf_ctrl_mixer - control and output end of an 8-bit Chamberlin state-variable filter.
//  - Holds the SID-style filter registers written over the voice bus.
//  - Generates the sample tick and the alpha1 (frequency) / alpha2 (damping) coefficients.
//  - Captures the hp/bp/lp taps, mixes the selected ones and applies master volume.
// Optional feature macro: SVF_CTRL_SLEW_EN (alpha1 slews toward its target by SLEW_STEP per tick).
module svf_ctrl_mixer #(
    parameter int CLK_DIV   = 16,
    parameter int SLEW_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       sample_valid,
    output logic [6:0] alpha1,
    output logic [3:0] alpha2,
    input  logic [7:0] filt_hp,
    input  logic [7:0] filt_bp,
    input  logic [7:0] filt_lp,
    output logic [7:0] mix_out,
    output logic       mix_valid
);

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [9:0] DIV_PRE  = 10'(CLK_DIV - 2);

    // Divider and tick
    logic [9:0] div_r;
    logic       sample_valid_r;

    // Filter registers
    logic [2:0] fc_lo_r;
    logic [7:0] fc_hi_r;
    logic [3:0] res_r;
    logic       mode_hp_r;
    logic       mode_bp_r;
    logic       mode_lp_r;
    logic [3:0] vol_r;

    // Coefficients
    logic [6:0]  alpha1_r;
    logic [3:0]  alpha2_r;
    logic [10:0] fc_s;
    logic [6:0]  tgt1_s;
    logic [6:0]  alpha1_next_s;
    logic [3:0]  alpha2_next_s;

    // Mixer pipeline
    logic signed [9:0]  sum_s;
    logic signed [9:0]  sum_r;
    logic               s1_valid_r;
    logic signed [13:0] sum_ext_s;
    logic signed [13:0] vol_ext_s;
    logic signed [13:0] prod_s;
    logic signed [13:0] q_s;
    logic        [7:0]  sat_s;
    logic        [7:0]  mix_out_r;
    logic               mix_valid_r;

    // Sign-extend an 8-bit signed tap to the 10-bit mixing width.
    function automatic logic signed [9:0] sext10(input logic [7:0] v);
        sext10 = $signed({{2{v[7]}}, v});
    endfunction

    // Sample divider: div counts 0..CLK_DIV-1; the tick is registered one count early so it is high while div==CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r          <= 10'd0;
            sample_valid_r <= 1'b0;
        end else begin
            if (div_r == DIV_LAST) begin
                div_r <= 10'd0;
            end else begin
                div_r <= div_r + 10'd1;
            end
            sample_valid_r <= (div_r == DIV_PRE);
        end
    end

    // Register file written by the voice bus; unused data bits are simply not stored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc_lo_r   <= 3'd0;
            fc_hi_r   <= 8'd0;
            res_r     <= 4'd0;
            mode_hp_r <= 1'b0;
            mode_bp_r <= 1'b0;
            mode_lp_r <= 1'b0;
            vol_r     <= 4'd0;
        end else if (reg_we) begin
            case (reg_addr)
                2'd0: fc_lo_r <= reg_wdata[2:0];
                2'd1: fc_hi_r <= reg_wdata;
                2'd2: res_r   <= reg_wdata[7:4];
                2'd3: begin
                    mode_hp_r <= reg_wdata[6];
                    mode_bp_r <= reg_wdata[5];
                    mode_lp_r <= reg_wdata[4];
                    vol_r     <= reg_wdata[3:0];
                end
                default: begin
                    fc_lo_r <= fc_lo_r;
                end
            endcase
        end else begin
            fc_lo_r <= fc_lo_r;
        end
    end

    assign fc_s   = {fc_hi_r, fc_lo_r};
    assign tgt1_s = fc_s[10:4];

    // Damping target: 15 - RES, floored at 2 to keep the loop stable.
    always_comb begin
        alpha2_next_s = 4'hF - res_r;
        if (res_r > 4'd13) begin
            alpha2_next_s = 4'd2;
        end else begin
            alpha2_next_s = 4'hF - res_r;
        end
    end

`ifdef SVF_CTRL_SLEW_EN
    localparam logic [6:0] STEP = 7'(SLEW_STEP);

    // Slewed frequency: step toward the target, landing exactly on it when closer than STEP.
    always_comb begin
        alpha1_next_s = alpha1_r;
        if (tgt1_s > alpha1_r) begin
            if ((tgt1_s - alpha1_r) > STEP) begin
                alpha1_next_s = alpha1_r + STEP;
            end else begin
                alpha1_next_s = tgt1_s;
            end
        end else if (tgt1_s < alpha1_r) begin
            if ((alpha1_r - tgt1_s) > STEP) begin
                alpha1_next_s = alpha1_r - STEP;
            end else begin
                alpha1_next_s = tgt1_s;
            end
        end else begin
            alpha1_next_s = alpha1_r;
        end
    end

    logic unused_s;
    assign unused_s = ^{fc_s[3:0]};
`else
    assign alpha1_next_s = tgt1_s;

    logic unused_s;
    assign unused_s = ^{fc_s[3:0], 7'(SLEW_STEP)};
`endif

    // Coefficient update at the edge closing the tick, so the SVF latches with the old alphas.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alpha1_r <= 7'd0;
            alpha2_r <= 4'hF;
        end else if (sample_valid_r) begin
            alpha1_r <= alpha1_next_s;
            alpha2_r <= alpha2_next_s;
        end else begin
            alpha1_r <= alpha1_r;
            alpha2_r <= alpha2_r;
        end
    end

    // Mode-selected tap sum; deselected taps contribute zero.
    always_comb begin
        sum_s = 10'sd0;
        if (mode_hp_r) begin
            sum_s = sum_s + sext10(filt_hp);
        end else begin
            sum_s = sum_s;
        end
        if (mode_bp_r) begin
            sum_s = sum_s + sext10(filt_bp);
        end else begin
            sum_s = sum_s;
        end
        if (mode_lp_r) begin
            sum_s = sum_s + sext10(filt_lp);
        end else begin
            sum_s = sum_s;
        end
    end

    // S1: capture the tap sum on the tick cycle (mode bits sampled here).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r      <= 10'sd0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= sample_valid_r;
            if (sample_valid_r) begin
                sum_r <= sum_s;
            end else begin
                sum_r <= sum_r;
            end
        end
    end

    assign sum_ext_s = {{4{sum_r[9]}}, sum_r};
    assign vol_ext_s = $signed({10'd0, vol_r});
    assign prod_s    = sum_ext_s * vol_ext_s;
    assign q_s       = prod_s >>> 4;

    // Saturate the scaled sample to the signed 8-bit range.
    always_comb begin
        sat_s = q_s[7:0];
        if (q_s > 14'sd127) begin
            sat_s = 8'h7F;
        end else if (q_s < -14'sd128) begin
            sat_s = 8'h80;
        end else begin
            sat_s = q_s[7:0];
        end
    end

    // S2: volume scale (VOL sampled here) and register the output sample with its strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_out_r   <= 8'd0;
            mix_valid_r <= 1'b0;
        end else begin
            mix_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                mix_out_r <= sat_s;
            end else begin
                mix_out_r <= mix_out_r;
            end
        end
    end

    assign sample_valid = sample_valid_r;
    assign alpha1       = alpha1_r;
    assign alpha2       = alpha2_r;
    assign mix_out      = mix_out_r;
    assign mix_valid    = mix_valid_r;

endmodule
